// File: rtl/iter_divider.sv
// Iterative radix-2^R restoring divider/remainder unit (RISC-V DIV/DIVU/REM/REMU)
// with branch-tag flush and single-cycle divide-by-zero / signed-overflow results.

package iter_divider_pkg;
  localparam int unsigned BR_TAG_WIDTH = 4;

  typedef struct packed {
    logic                    sign;
    logic [BR_TAG_WIDTH-1:0] tag;
  } branch_tag_t;
endpackage

module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int unsigned OPERAND_WIDTH  = 32,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned ID_WIDTH       = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_op,
  input  logic [OPERAND_WIDTH-1:0] req_a,
  input  logic [OPERAND_WIDTH-1:0] req_b,
  input  logic [ID_WIDTH-1:0]      req_id,
  input  branch_tag_t              req_br_tag,
  input  logic                     flush,
  input  branch_tag_t              flush_tag,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [OPERAND_WIDTH-1:0] resp_data,
  output logic [ID_WIDTH-1:0]      resp_id,
  output branch_tag_t              resp_br_tag,
  output logic                     busy
);

  localparam int unsigned W     = OPERAND_WIDTH;
  localparam int unsigned R     = BITS_PER_CYCLE;
  localparam int unsigned N     = W / R;
  localparam int unsigned CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  // Same-sign tags: flushed tag is an ancestor of ours; otherwise the reverse.
  function automatic logic tag_match(input branch_tag_t t, input branch_tag_t f);
    logic m;
    if (t.sign == f.sign) m = ((t.tag & f.tag) == f.tag);
    else                  m = ((t.tag & f.tag) == t.tag);
    return m;
  endfunction

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  branch_tag_t        tag_q, tag_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [W-1:0]       rem_q, rem_d;
  logic [W-1:0]       dvd_q, dvd_d;
  logic [W-1:0]       dsr_q, dsr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       data_q, data_d;

  logic               accept;
  logic               kill_req;
  logic               kill_cur;
  logic               signed_op;
  logic               is_rem;
  logic               a_neg;
  logic               b_neg;
  logic [W-1:0]       a_mag;
  logic [W-1:0]       b_mag;
  logic               b_zero;
  logic               ovf;
  logic [W:0]         step_t;
  logic [W-1:0]       step_r;
  logic [W-1:0]       step_q;
  logic [W-1:0]       fix_quo;
  logic [W-1:0]       fix_rem;

  // Request decode: signs and magnitudes of the incoming operands.
  always_comb begin
    signed_op = ~req_op[0];
    is_rem    = req_op[1];
    a_neg     = signed_op & req_a[W-1];
    b_neg     = signed_op & req_b[W-1];
    a_mag     = a_neg ? (W'(0) - req_a) : req_a;
    b_mag     = b_neg ? (W'(0) - req_b) : req_b;
    b_zero    = (req_b == '0);
    ovf       = signed_op && (req_a == {1'b1, {(W-1){1'b0}}}) && (req_b == '1);
    accept    = req_valid && (state_q == S_IDLE);
    kill_req  = flush && tag_match(req_br_tag, flush_tag);
    kill_cur  = flush && tag_match(tag_q, flush_tag);
  end

  // R restoring steps; dvd shifts dividend bits out the top and quotient bits in the bottom.
  always_comb begin
    step_t = '0;
    step_r = rem_q;
    step_q = dvd_q;
    for (int unsigned i = 0; i < R; i++) begin
      step_t = {step_r, step_q[W-1]};
      step_q = {step_q[W-2:0], 1'b0};
      if (step_t >= {1'b0, dsr_q}) begin
        step_t    = step_t - {1'b0, dsr_q};
        step_q[0] = 1'b1;
      end
      step_r = step_t[W-1:0];
    end
  end

  // Sign correction; unsigned ops always carry clear sign flags.
  always_comb begin
    fix_quo = dvd_q;
    fix_rem = rem_q;
    if (!op_q[1] && (sa_q ^ sb_q)) fix_quo = W'(0) - dvd_q;
    if (op_q[1] && sa_q)           fix_rem = W'(0) - rem_q;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    tag_d   = tag_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE: begin
        if (accept && !kill_req) begin
          op_d  = req_op;
          id_d  = req_id;
          tag_d = req_br_tag;
          sa_d  = a_neg;
          sb_d  = b_neg;
          if (b_zero) begin
            data_d  = is_rem ? req_a : '1;
            state_d = S_DONE;
          end else if (ovf) begin
            data_d  = is_rem ? '0 : req_a;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            dvd_d   = a_mag;
            dsr_d   = b_mag;
            cnt_d   = CNT_W'(N);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step_r;
        dvd_d = step_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        data_d  = op_q[1] ? fix_rem : fix_quo;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A matching flush squashes the in-flight op, including a pending response.
    if (kill_cur && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      id_q    <= '0;
      tag_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      id_q    <= id_d;
      tag_q   <= tag_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign resp_valid  = (state_q == S_DONE);
  assign resp_data   = data_q;
  assign resp_id     = id_q;
  assign resp_br_tag = tag_q;

endmodule

// File: doc/iter_divider.md
# iter_divider

Parametrised iterative integer divider/remainder unit for the out-of-order core's execute stage, covering RISC-V DIV, DIVU, REM and REMU. It accepts one request per operation through a valid/ready handshake and computes in a radix-2^R restoring loop. It returns the result with its issue ID and branch tag through a second valid/ready handshake. Branch-tag flushes squash the in-flight operation in any state, and the RISC-V divide-by-zero and signed-overflow results are produced in a single cycle.

## Interface
- OPERAND_WIDTH, 32, operand/result width W (even, ≥8)
- BITS_PER_CYCLE, 1, quotient bits retired per iteration R; legal values 1, 2, 4; W % R == 0
- ID_WIDTH, 6, width of the pass-through issue ID (ROB index)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a  in  W  dividend
- req_b  in  W  divisor
- req_id  in  ID_WIDTH  issue ID
- req_br_tag  in  branch_tag_t  speculation tag of the request
- flush  in  1  branch-mispredict flush strobe
- flush_tag  in  branch_tag_t  tag being flushed
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_data  out  W  quotient or remainder
- resp_id  out  ID_WIDTH  ID of the result
- resp_br_tag  out  branch_tag_t  tag of the result
- busy  out  1  state != IDLE

## Operation
- States are IDLE, CALC, FIX and DONE.
- **Accept.** An accept is req_valid && req_ready at a rising edge.
  - On accept, latch op, id, br_tag, operand signs and |a|, |b|.
  - For DIVU/REMU the magnitude is the raw operand.
  - For DIV/REM the magnitude is the two's-complement absolute value; the most-negative value stays unchanged when treated as unsigned.
- **IDLE transitions on accept:**
  - If b == 0, go to DONE with resp_data = all-ones for DIV/DIVU and resp_data = a for REM/REMU.
  - If the op is signed, a == 100…0 and b == all-ones, go to DONE with resp_data = a for DIV and 0 for REM.
  - Otherwise go to CALC with an iteration counter of N = W/R.
- **CALC.** Each cycle performs R restoring steps: shift the partial remainder left by one, bringing in the next dividend MSB; compare it with |b|; subtract if it is ≥ |b|; shift the resulting bit into the quotient.
  - The counter decrements each cycle; when it reaches 1, go to FIX.
- **FIX.**
  - Quotient: negate if the op is DIV and sign(a) != sign(b).
  - Remainder: negate if the op is REM and sign(a) is negative.
  - Register resp_data as the quotient (DIV/DIVU) or remainder (REM/REMU), then go to DONE.
- **DONE.** resp_valid = 1.
  - resp_data, resp_id and resp_br_tag stay stable until resp_ready is sampled high.
  - On resp_ready, go to IDLE.
- **Flush match rule**, for a stored tag t and flush_tag f:
  - if t.sign == f.sign, the tag matches when (t.tag & f.tag) == f.tag;
  - otherwise it matches when (t.tag & f.tag) == t.tag.
- **Flush behaviour:**
  - In CALC, FIX or DONE, flush with a matching stored tag sends the next state to IDLE, with no response and resp_valid low the next cycle.
  - A flush that does not match leaves the state unchanged.
  - An accept in the same cycle as a flush that matches req_br_tag is discarded, and the state stays IDLE.
  - Flush in DONE together with resp_ready: the flush wins and the result is dropped.

## Timing
- **Reset** (rst_n low, asynchronous): state IDLE, req_ready 1, resp_valid 0, busy 0, and resp_data, resp_id, resp_br_tag and the internal datapath registers all 0.
- **Latency** is counted from the accept edge:
  - normal ops: resp_valid is high in cycle N+2 (W=32, R=1 gives 34; R=4 gives 10);
  - divide-by-zero and overflow: resp_valid is high in cycle 1.
- **Throughput:** one operation in flight. After the resp handshake edge the unit is in IDLE, so the next accept is at the following edge at the earliest.
- req_ready and busy are decoded from the state register; there is no combinational path from req_valid.
- resp_valid is a pure function of state (state == DONE); all outputs are registered.

## Test plan
- **Unsigned divide.** W=32, R=1: DIVU a=100, b=7 → resp_data=14 at cycle 34. REMU with the same operands → 2, and resp_id echoes req_id=5.
- **Signed divide.** DIV a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1). REM a=7, b=-2 → 1.
- **Special cases.** DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000 with resp_valid at cycle 1. DIVU a=5, b=0 → 0xFFFFFFFF. REM a=5, b=0 → 5 at cycle 1.
- **Back-pressure.** resp_ready is held low for 10 cycles in DONE → resp_valid and resp_data stay stable and req_ready stays 0. Raise resp_ready → IDLE at the next edge.
- **Flush matching.** Stored tag {sign=0, tag=0b0011}, flush_tag {0, 0b0001} in CALC cycle 10 → next cycle is IDLE with no response. Flush_tag {0, 0b0100} → no effect, and the result arrives on schedule.
- **Parameter sweep and reset.** R=2 and R=4 on 1000 random operands each are checked against a reference model, with latency N+2. Asserting rst_n low mid-CALC clears resp_valid and busy immediately.
